// File: rtl/sram_arb_pkg.sv
// Shared constants for the two-port SRAM arbiter: FSM encoding, port indices, LAT range.
// Round-robin arbitration is selected with SRAM_ARB_RR_EN; fixed priority otherwise.
package sram_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  function automatic bit lat_ok(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection between the LSU and debug ports, zero latency, no backpressure.
// SRAM_ARB_RR_EN: ties go to the port not named by rr_ptr; otherwise the LSU port always wins.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic win_vld,
  output logic win_idx
);

  assign win_vld = req0 | req1;

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    win_idx = PORT_LSU;
    if (req0 && req1) begin
      win_idx = ~rr_ptr;
    end else if (req1) begin
      win_idx = PORT_DBG;
    end
  end
`else
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr;
  assign win_idx       = req0 ? PORT_LSU : PORT_DBG;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for a single-ported SRAM: gnt in IDLE, LAT access cycles, ack one cycle later.
// One access in flight; requesters hold req until gnt. SRAM_ARB_RR_EN selects round-robin arbitration.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  if (!lat_ok(LAT)) begin : g_lat_check
    $error("sram_arbiter: LAT out of range 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              owner;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              rr_ptr;
  logic              win_vld;
  logic              win_idx;
  logic              take;

  sram_arb_pick u_pick (
    .req0    (req0),
    .req1    (req1),
    .rr_ptr  (rr_ptr),
    .win_vld (win_vld),
    .win_idx (win_idx)
  );

  // Grant is only offered while idle and never while reset is asserted.
  assign take = !rst && (state == ST_IDLE) && win_vld;

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b1;
    end else if (take) begin
      rr_ptr <= win_idx;
    end
  end
`else
  assign rr_ptr = 1'b1;
`endif

  assign gnt0 = take && (win_idx == PORT_LSU);
  assign gnt1 = take && (win_idx == PORT_DBG);
  assign ack0 = (state == ST_DONE) && (owner == PORT_LSU);
  assign ack1 = (state == ST_DONE) && (owner == PORT_DBG);

  // Address and data come straight from the command register so they hold between accesses.
  assign sram_cs   = (state == ST_ACCESS);
  assign sram_oe   = sram_cs && !cmd_we;
  assign sram_we   = sram_cs && cmd_we;
  assign sram_addr = cmd_addr;
  assign sram_din  = cmd_wdata;
  assign rdata     = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      owner     <= PORT_LSU;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            owner     <= win_idx;
            cmd_we    <= win_idx ? we1 : we0;
            cmd_addr  <= win_idx ? addr1 : addr0;
            cmd_wdata <= win_idx ? wdata1 : wdata0;
            cnt       <= CNT_LOAD;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            if (!cmd_we) begin
              rdata_q <= sram_dout;
            end
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
